// File: rtl/and_op_unit_if.sv
// Operand/result bundle for and_op_unit.
// Bit 0 is the MSB (big-endian numbering) on every vector.
// ANDOP_COND_EN adds the cond selector and the cond_true result.
interface and_op_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic [0:WIDTH-1] a;
  logic [0:WIDTH-1] b;
  logic             neg_a;
  logic             neg_b;
  logic             neg_res;
  logic [0:WIDTH-1] y;
  logic             out_valid;
  logic             zero;
`ifdef ANDOP_COND_EN
  logic [2:0]       cond;
  logic             cond_true;

  modport master (
    output in_valid, a, b, neg_a, neg_b, neg_res, cond,
    input  y, out_valid, zero, cond_true
  );

  modport slave (
    input  in_valid, a, b, neg_a, neg_b, neg_res, cond,
    output y, out_valid, zero, cond_true
  );
`else
  modport master (
    output in_valid, a, b, neg_a, neg_b, neg_res,
    input  y, out_valid, zero
  );

  modport slave (
    input  in_valid, a, b, neg_a, neg_b, neg_res,
    output y, out_valid, zero
  );
`endif
endinterface

// File: rtl/and_op_unit.sv
// Registered logical AND unit for the VCPU-32 execute stage.
// y = ((neg_a ? ~a : a) & (neg_b ? ~b : b)) ^ {neg_res}: AND, ANDCM, NAND, NOR.
// One register stage, valid tracking, zero flag.
// Optional macro ANDOP_COND_EN adds the registered condition evaluator.
module and_op_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  and_op_unit_if.slave op
);

  logic [0:WIDTH-1] opa_c;
  logic [0:WIDTH-1] opb_c;
  logic [0:WIDTH-1] res_c;

  logic [0:WIDTH-1] y_q;
  logic [0:WIDTH-1] y_d;
  logic             zero_q;
  logic             zero_d;
  logic             valid_q;
  logic             valid_d;

`ifdef ANDOP_COND_EN
  logic             cond_q;
  logic             cond_d;

  // Condition codes evaluated on the unregistered result; bit 0 is the sign bit.
  function automatic logic cond_eval(input logic [2:0] sel, input logic [0:WIDTH-1] r);
    logic hit;
    hit = 1'b0;
    case (sel)
      3'd0:    hit = 1'b0;
      3'd1:    hit = (r == '0);
      3'd2:    hit = (r != '0);
      3'd3:    hit = r[0];
      3'd4:    hit = ~r[0];
      3'd5:    hit = r[WIDTH-1];
      3'd6:    hit = ~r[WIDTH-1];
      default: hit = 1'b1;
    endcase
    return hit;
  endfunction
`endif

  // Bitwise datapath with optional operand/result complement.
  always_comb begin
    opa_c = op.neg_a ? ~op.a : op.a;
    opb_c = op.neg_b ? ~op.b : op.b;
    res_c = (opa_c & opb_c) ^ {WIDTH{op.neg_res}};
  end

  // Next-state: capture on in_valid, otherwise hold result and drop valid.
  always_comb begin
    y_d     = y_q;
    zero_d  = zero_q;
    valid_d = 1'b0;
`ifdef ANDOP_COND_EN
    cond_d  = cond_q;
`endif
    if (op.in_valid) begin
      y_d     = res_c;
      zero_d  = (res_c == '0);
      valid_d = 1'b1;
`ifdef ANDOP_COND_EN
      cond_d  = cond_eval(op.cond, res_c);
`endif
    end
  end

  // Result register stage; async reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef ANDOP_COND_EN
      cond_q  <= 1'b0;
`endif
    end else begin
      y_q     <= y_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
`ifdef ANDOP_COND_EN
      cond_q  <= cond_d;
`endif
    end
  end

  // Outputs come straight from registers.
  assign op.y         = y_q;
  assign op.zero      = zero_q;
  assign op.out_valid = valid_q;
`ifdef ANDOP_COND_EN
  assign op.cond_true = cond_q;
`endif

endmodule

// File: tb/tb_and_op_unit.sv
// Scoreboard bench for and_op_unit: the driver pushes hand-computed
// expectations, a negedge monitor pops and compares on out_valid.
// Condition checks are active when ANDOP_COND_EN is defined.
module tb_and_op_unit;

  localparam int unsigned WIDTH = 32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        na;
    logic        nb;
    logic        nr;
    logic [2:0]  c;
    logic [31:0] ey;
    logic        ez;
    logic        ec;
  } vec_t;

  typedef struct {
    logic [31:0] y;
    logic        z;
    logic        c;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  vec_t vecs[12];

  and_op_unit_if #(.WIDTH(WIDTH)) bus ();

  and_op_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .op    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every presented result must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: y=%08h with empty scoreboard at %0t", bus.y, $time);
      end else begin
        e = exp_q.pop_front();
        check("y", 32'(bus.y), e.y);
        check("zero", 32'(bus.zero), 32'(e.z));
`ifdef ANDOP_COND_EN
        check("cond_true", 32'(bus.cond_true), 32'(e.c));
`endif
      end
    end
  end

  task automatic issue(input vec_t v);
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.neg_a    = v.na;
    bus.neg_b    = v.nb;
    bus.neg_res  = v.nr;
`ifdef ANDOP_COND_EN
    bus.cond     = v.c;
`endif
    e.y = v.ey;
    e.z = v.ez;
    e.c = v.ec;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = a;
    bus.b        = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n       = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.neg_a    = 1'b0;
    bus.neg_b    = 1'b0;
    bus.neg_res  = 1'b0;
`ifdef ANDOP_COND_EN
    bus.cond     = 3'd0;
`endif

    //            a             b             na    nb    nr    c     ey            ez    ec
    vecs[0]  = '{32'h00F010FF, 32'h00000000, 1'b0, 1'b0, 1'b0, 3'd1, 32'h00000000, 1'b1, 1'b1};
    vecs[1]  = '{32'h00F010FF, 32'hF0FFFFFF, 1'b0, 1'b0, 1'b0, 3'd2, 32'h00F010FF, 1'b0, 1'b1};
    vecs[2]  = '{32'h07F010FF, 32'h70FFF000, 1'b0, 1'b0, 1'b0, 3'd5, 32'h00F01000, 1'b0, 1'b0};
    vecs[3]  = '{32'hFFFFFFFF, 32'h0000FFFF, 1'b0, 1'b1, 1'b0, 3'd3, 32'hFFFF0000, 1'b0, 1'b1};
    vecs[4]  = '{32'hFFFFFFFF, 32'h0000FFFF, 1'b0, 1'b0, 1'b1, 3'd4, 32'hFFFF0000, 1'b0, 1'b0};
    vecs[5]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 3'd7, 32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[6]  = '{32'h0F0F0F0F, 32'hFFFF0000, 1'b1, 1'b0, 1'b0, 3'd0, 32'hF0F00000, 1'b0, 1'b0};
    vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 3'd6, 32'h00000000, 1'b1, 1'b1};
    vecs[8]  = '{32'h80000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 3'd3, 32'h80000001, 1'b0, 1'b1};
    vecs[9]  = '{32'h80000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 3'd6, 32'h80000001, 1'b0, 1'b0};
    vecs[10] = '{32'h80000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 3'd1, 32'h80000001, 1'b0, 1'b0};
    vecs[11] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 3'd1, 32'h00000000, 1'b1, 1'b1};

    // Reset state, held and after release.
    repeat (3) @(negedge clk);
    #1;
    check("rst_y", 32'(bus.y), 32'h0);
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_zero", 32'(bus.zero), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_valid", 32'(bus.out_valid), 32'h0);
    check("post_rst_y", 32'(bus.y), 32'h0);

    // Back-to-back stream through the scoreboard.
    foreach (vecs[i]) issue(vecs[i]);
    idle(32'h0, 32'h0);

    // Single pulse then idle with changing operands: outputs hold, valid drops.
    issue(vecs[1]);
    idle(32'h12345678, 32'hFFFFFFFF);
    @(negedge clk);
    #1;
    check("hold_valid", 32'(bus.out_valid), 32'h0);
    check("hold_y", 32'(bus.y), 32'h00F010FF);
    check("hold_zero", 32'(bus.zero), 32'h0);
    bus.a = 32'hFFFFFFFF;
    @(negedge clk);
    #1;
    check("hold2_y", 32'(bus.y), 32'h00F010FF);
    check("hold2_valid", 32'(bus.out_valid), 32'h0);

    // Asynchronous reset while a result is valid clears outputs without an edge.
    issue(vecs[3]);
    idle(32'h0, 32'h0);
    #1;
    check("pre_arst_valid", 32'(bus.out_valid), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_y", 32'(bus.y), 32'h0);
    check("arst_valid", 32'(bus.out_valid), 32'h0);
    check("arst_zero", 32'(bus.zero), 32'h0);
`ifdef ANDOP_COND_EN
    check("arst_cond", 32'(bus.cond_true), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Everything issued must have been seen, within a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
